// File: rtl/isp1761_resp_pkg.sv
// isp1761_resp_pkg: shared constants for the ISP1761-style bus responder.
// Holds register map indices, the bus FSM state type and the HC/DC status field masks.
package isp1761_resp_pkg;

    localparam int IDX_ID     = 0;
    localparam int IDX_STATUS = 1;
    localparam int IDX_ENABLE = 2;

    localparam logic [31:0] HC_MASK = 32'h0000_FFFF;
    localparam logic [31:0] DC_MASK = 32'hFFFF_0000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_CAP  = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_RD_DRV  = 3'd3,
        ST_RD_TURN = 3'd4
    } state_t;

endpackage

// File: rtl/isp_strobe_sync.sv
// isp_strobe_sync: STG-flop synchronizer for one asynchronous bus input.
// RST_VAL lets active-low strobes come out of reset in their inactive (high) state.
module isp_strobe_sync #(
    parameter int   STG     = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STG-1:0] sync_q;

    // Shift the raw input through the flop chain; the last stage is the synced value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {STG{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STG-2:0], d_i};
        end
    end

    assign q_o = sync_q[STG-1];

endmodule

// File: rtl/isp1761_bus_responder.sv
// isp1761_bus_responder: bus-target side of an ISP1761-style async 32-bit parallel bus.
// Optional DMA request handshake (dma_req/DC_DREQ/DC_DACK) is built when ISP_RESP_DREQ_EN is defined.
module isp1761_bus_responder #(
    parameter int          DEPTH    = 16,
    parameter logic [31:0] ID_VALUE = 32'h1761_0001,
    parameter int          SYNC_STG = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     CS_N,
    input  logic                     WR_N,
    input  logic                     RD_N,
    input  logic [17:1]              A,
    inout  wire  [31:0]              D,
    output logic                     HC_IRQ,
    output logic                     DC_IRQ,
    input  logic [31:0]              evt_set,
    output logic                     wr_stb,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic [31:0]              wr_data,
    output logic                     proto_err
`ifdef ISP_RESP_DREQ_EN
    ,
    input  logic                     dma_req,
    output logic                     DC_DREQ,
    input  logic                     DC_DACK
`endif
);
    import isp1761_resp_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] I_ID     = IDX_W'(IDX_ID);
    localparam logic [IDX_W-1:0] I_STATUS = IDX_W'(IDX_STATUS);
    localparam logic [IDX_W-1:0] I_ENABLE = IDX_W'(IDX_ENABLE);

    logic cs_s, rd_s, wr_s;
    logic wr_act, rd_act, both_low;
    logic [IDX_W-1:0] idx;
    logic unused_a;

    state_t state_q, state_d;
    logic oe, cap, rd_load, proto_set;

    logic [31:0] rd_q, rd_word;
    logic [31:0] status_q, status_d, enable_q, enable_d, w1c_mask;
    logic [31:0] mem_q [DEPTH];
    logic hc_irq_q, dc_irq_q, wr_stb_q, proto_q;
    logic [IDX_W-1:0] wr_addr_q;
    logic [31:0] wr_data_q;

    isp_strobe_sync #(.STG(SYNC_STG), .RST_VAL(1'b1)) u_cs_sync (.clk(clk), .reset(reset), .d_i(CS_N), .q_o(cs_s));
    isp_strobe_sync #(.STG(SYNC_STG), .RST_VAL(1'b1)) u_rd_sync (.clk(clk), .reset(reset), .d_i(RD_N), .q_o(rd_s));
    isp_strobe_sync #(.STG(SYNC_STG), .RST_VAL(1'b1)) u_wr_sync (.clk(clk), .reset(reset), .d_i(WR_N), .q_o(wr_s));

    assign wr_act   = ~cs_s & ~wr_s &  rd_s;
    assign rd_act   = ~cs_s & ~rd_s &  wr_s;
    assign both_low = ~cs_s & ~rd_s & ~wr_s;

    // A[1] and the bits above the word index never reach the register file.
    assign idx      = A[IDX_W+1:2];
    assign unused_a = ^{A[17:IDX_W+2], A[1]};

    // Bus FSM next state and per-state control strobes.
    always_comb begin
        state_d   = state_q;
        oe        = 1'b0;
        cap       = 1'b0;
        rd_load   = 1'b0;
        proto_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_act) begin
                    state_d = ST_WR_CAP;
                end else if (rd_act) begin
                    state_d = ST_RD_DRV;
                    rd_load = 1'b1;
                end else if (both_low) begin
                    proto_set = 1'b1;
                end
            end
            ST_WR_CAP: begin
                cap     = 1'b1;
                state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (wr_s | cs_s) state_d = ST_IDLE;
            end
            ST_RD_DRV: begin
                oe = 1'b1;
                if (!rd_act) state_d = ST_RD_TURN;
            end
            ST_RD_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read mux and register-file next values; an event set beats a W1C on the same bit.
    always_comb begin
        case (idx)
            I_ID:     rd_word = ID_VALUE;
            I_STATUS: rd_word = status_q;
            I_ENABLE: rd_word = enable_q;
            default:  rd_word = mem_q[idx];
        endcase
        w1c_mask = (cap && idx == I_STATUS) ? D : 32'h0;
        status_d = (status_q & ~w1c_mask) | evt_set;
        enable_d = (cap && idx == I_ENABLE) ? D : enable_q;
    end

    // State, register file, write report, IRQ and protocol-error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rd_q      <= 32'h0;
            status_q  <= 32'h0;
            enable_q  <= 32'h0;
            hc_irq_q  <= 1'b0;
            dc_irq_q  <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 32'h0;
            proto_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            enable_q <= enable_d;
            hc_irq_q <= |(status_q & enable_q & HC_MASK);
            dc_irq_q <= |(status_q & enable_q & DC_MASK);
            wr_stb_q <= cap;
            if (rd_load) rd_q <= rd_word;
            if (proto_set) proto_q <= 1'b1;
            if (cap) begin
                wr_addr_q <= idx;
                wr_data_q <= D;
                if (idx > I_ENABLE) mem_q[idx] <= D;
            end
        end
    end

    // Raw strobes gate the driver so D lets go the instant the host ends the read.
    assign D = (oe & ~CS_N & ~RD_N) ? rd_q : 32'hz;

    assign HC_IRQ    = hc_irq_q;
    assign DC_IRQ    = dc_irq_q;
    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign proto_err = proto_q;

`ifdef ISP_RESP_DREQ_EN
    logic dack_s, dack_prev_q, dreq_q;

    isp_strobe_sync #(.STG(SYNC_STG), .RST_VAL(1'b1)) u_dack_sync (.clk(clk), .reset(reset), .d_i(DC_DACK), .q_o(dack_s));

    // DMA request holds until the synced acknowledge falls; a new request in that cycle wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dack_prev_q <= 1'b1;
            dreq_q      <= 1'b0;
        end else begin
            dack_prev_q <= dack_s;
            dreq_q      <= dma_req | (dreq_q & ~(dack_prev_q & ~dack_s));
        end
    end

    assign DC_DREQ = dreq_q;
`endif

endmodule

// File: tb/tb_isp1761_bus_responder.sv
// tb_isp1761_bus_responder: scoreboard bench for the ISP1761-style bus responder.
// Reads and writes push expected results into queues; read sampling and the wr_stb monitor pop them.
module tb_isp1761_bus_responder;

    localparam logic [31:0] ID_VAL   = 32'h1761_0001;
    localparam logic [31:0] RELEASED = 32'hFFFF_FFFF;

    logic        clk, reset, CS_N, WR_N, RD_N;
    logic [17:1] A;
    tri1  [31:0] D;
    logic [31:0] tbData;
    logic        tbDrive;
    logic        HC_IRQ, DC_IRQ, wr_stb, proto_err;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data, evt_set;
`ifdef ISP_RESP_DREQ_EN
    logic dma_req, DC_DACK, DC_DREQ;
`endif

    int testsRun = 0;
    int failCount = 0;
    int wrCount = 0;
    logic [31:0] rdQ[$];
    logic [35:0] wrQ[$];

    assign D = tbDrive ? tbData : 32'hz;

    isp1761_bus_responder dut (
        .clk(clk), .reset(reset), .CS_N(CS_N), .WR_N(WR_N), .RD_N(RD_N), .A(A), .D(D),
        .HC_IRQ(HC_IRQ), .DC_IRQ(DC_IRQ), .evt_set(evt_set), .wr_stb(wr_stb),
        .wr_addr(wr_addr), .wr_data(wr_data), .proto_err(proto_err)
`ifdef ISP_RESP_DREQ_EN
        , .dma_req(dma_req), .DC_DREQ(DC_DREQ), .DC_DACK(DC_DACK)
`endif
    );

    // 100 MHz bus-target clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Every write report from the DUT must match the oldest queued write.
    always @(negedge clk) begin
        if (!reset && wr_stb) begin
            wrCount++;
            if (wrQ.size() == 0) begin
                checkOutput("wr_unexpected", 32'd1, 32'd0);
            end else begin
                logic [35:0] e;
                e = wrQ.pop_front();
                checkOutput("wr_addr", {28'h0, wr_addr}, {28'h0, e[35:32]});
                checkOutput("wr_data", wr_data, e[31:0]);
            end
        end
    end

    task automatic busWrite(input int word, input logic [31:0] data, input logic [31:0] evt);
        wrQ.push_back({word[3:0], data});
        @(negedge clk);
        A = 17'(word * 2);
        tbData = data; tbDrive = 1'b1;
        CS_N = 1'b0; WR_N = 1'b0;
        repeat (3) @(negedge clk);
        evt_set = evt;
        @(negedge clk);
        evt_set = 32'h0;
        repeat (2) @(negedge clk);
        WR_N = 1'b1; CS_N = 1'b1;
        @(negedge clk);
        tbDrive = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic busRead(input int word, input logic half, input logic [31:0] exp);
        logic [31:0] e;
        rdQ.push_back(exp);
        @(negedge clk);
        A = 17'(word * 2) | {16'h0, half};
        CS_N = 1'b0; RD_N = 1'b0;
        repeat (2) @(posedge clk);
        #1 checkOutput("rd_early", D, RELEASED);
        @(posedge clk);
        #1 e = rdQ.pop_front();
        checkOutput("rd_data", D, e);
        repeat (5) @(posedge clk);
        #2 RD_N = 1'b1;
        #1 checkOutput("rd_release", D, RELEASED);
        CS_N = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic pulseEvt(input logic [31:0] evt);
        @(negedge clk);
        evt_set = evt;
        @(negedge clk);
        evt_set = 32'h0;
    endtask

    task automatic applyStimulus();
        int wc;
        // Reset state
        checkOutput("rst_hc_irq", {31'h0, HC_IRQ}, 32'h0);
        checkOutput("rst_dc_irq", {31'h0, DC_IRQ}, 32'h0);
        checkOutput("rst_wr_stb", {31'h0, wr_stb}, 32'h0);
        checkOutput("rst_wr_addr", {28'h0, wr_addr}, 32'h0);
        checkOutput("rst_wr_data", wr_data, 32'h0);
        checkOutput("rst_proto", {31'h0, proto_err}, 32'h0);
        checkOutput("rst_d", D, RELEASED);
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);

        // ID word, write/readback, read-only ID, index extremes and ignored A[1]
        busRead(0, 1'b0, ID_VAL);
        busWrite(5, 32'hA5A5_5A5A, 32'h0);
        busRead(5, 1'b0, 32'hA5A5_5A5A);
        busWrite(0, 32'hDEAD_BEEF, 32'h0);
        busRead(0, 1'b0, ID_VAL);
        busWrite(3, 32'h1234_5678, 32'h0);
        busWrite(15, 32'h0F0F_00FF, 32'h0);
        busRead(3, 1'b0, 32'h1234_5678);
        busRead(15, 1'b1, 32'h0F0F_00FF);
        busRead(5, 1'b1, 32'hA5A5_5A5A);
        checkOutput("wr_count", wrCount, 32'd4);

        // IRQ from status & enable, cleared through W1C
        busWrite(2, 32'h0002_0001, 32'h0);
        busRead(2, 1'b0, 32'h0002_0001);
        @(negedge clk); evt_set = 32'h1;
        @(negedge clk); evt_set = 32'h0;
        checkOutput("hc_irq_lag", {31'h0, HC_IRQ}, 32'h0);
        @(negedge clk);
        checkOutput("hc_irq_set", {31'h0, HC_IRQ}, 32'h1);
        busRead(1, 1'b0, 32'h1);
        busRead(1, 1'b0, 32'h1);
        busWrite(1, 32'h1, 32'h0);
        checkOutput("hc_irq_clr", {31'h0, HC_IRQ}, 32'h0);
        pulseEvt(32'h0002_0000);
        @(negedge clk);
        checkOutput("dc_irq_set", {31'h0, DC_IRQ}, 32'h1);
        checkOutput("dc_hc_quiet", {31'h0, HC_IRQ}, 32'h0);
        busWrite(1, 32'h0002_0000, 32'h0);
        checkOutput("dc_irq_clr", {31'h0, DC_IRQ}, 32'h0);

        // Set beats clear on bit 3 while bit 4 clears normally
        pulseEvt(32'h10);
        busWrite(1, 32'h18, 32'h8);
        busRead(1, 1'b0, 32'h8);

        // All strobes low: protocol error, no write, bus released
        wc = wrCount;
        @(negedge clk);
        A = 17'(6 * 2); CS_N = 1'b0; RD_N = 1'b0; WR_N = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("perr_set", {31'h0, proto_err}, 32'h1);
        checkOutput("perr_d", D, RELEASED);
        CS_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("perr_sticky", {31'h0, proto_err}, 32'h1);
        checkOutput("perr_no_wr", wrCount, wc);

        // Reset in the middle of a read drops the bus at once
        @(negedge clk);
        A = 17'(0); CS_N = 1'b0; RD_N = 1'b0;
        repeat (4) @(posedge clk);
        #1 checkOutput("mid_rd_data", D, ID_VAL);
        reset = 1'b1;
        #1 checkOutput("mid_rst_d", D, RELEASED);
        checkOutput("mid_rst_perr", {31'h0, proto_err}, 32'h0);
        @(negedge clk);
        RD_N = 1'b1; CS_N = 1'b1;
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
        busRead(5, 1'b0, 32'h0);
        busRead(0, 1'b0, ID_VAL);

`ifdef ISP_RESP_DREQ_EN
        // DMA request sets on a pulse and clears after the synced acknowledge falls
        @(negedge clk); dma_req = 1'b1;
        @(negedge clk); dma_req = 1'b0;
        checkOutput("dreq_set", {31'h0, DC_DREQ}, 32'h1);
        repeat (3) @(negedge clk);
        checkOutput("dreq_hold", {31'h0, DC_DREQ}, 32'h1);
        DC_DACK = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("dreq_clr", {31'h0, DC_DREQ}, 32'h0);
        DC_DACK = 1'b1;
`endif
        checkOutput("rd_queue_empty", rdQ.size(), 32'd0);
        checkOutput("wr_queue_empty", wrQ.size(), 32'd0);
    endtask

    // Drive reset, run the whole sequence, then report.
    initial begin
        reset = 1'b1; CS_N = 1'b1; WR_N = 1'b1; RD_N = 1'b1;
        A = '0; tbData = 32'h0; tbDrive = 1'b0; evt_set = 32'h0;
`ifdef ISP_RESP_DREQ_EN
        dma_req = 1'b0; DC_DACK = 1'b1;
`endif
        repeat (3) @(negedge clk);
        applyStimulus();
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
